ps2_led_cmd_tx: RTL and testbench
=================================

Name: ps2_led_cmd_tx

Overview:
- Host-to-keyboard command sender for the PS/2 link; it drives the transmit side of PS2_Controller (the_command / send_command / command_was_sent / error_communication_timed_out).
- Sends the keyboard "Set LEDs" sequence: 0xED, wait for ACK 0xFA, then the LED byte, wait for ACK 0xFA.
- Handles resend (0xFE), ACK timeout and bounded retries.
- Sits beside input_interface so the sequencer can show mode/play status on the keyboard LEDs.

Parameters:
- ACK_TIMEOUT, 2_500_000, cycles to wait for an ACK after a byte is sent (50 ms at 50 MHz).
- MAX_RETRY, 3, maximum re-sends of one byte before the sequence is aborted.
- CNT_W, 22, width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain)
- nReset  in  1  asynchronous active-low reset
- led_state  in  3  {caps, num, scroll} requested LED levels
- req  in  1  one-cycle pulse requesting an LED update
- received_data  in  8  byte from PS2_Controller
- received_data_en  in  1  one-cycle valid for received_data
- command_was_sent  in  1  controller finished clocking out the_command
- error_communication_timed_out  in  1  controller transmit failure
- the_command  out  8  byte to transmit
- send_command  out  1  transmit request level to the controller
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse when both ACKs are received
- error  out  1  one-cycle pulse when the sequence is aborted

Behaviour:
- Reset values: state IDLE; the_command=0x00, send_command=0, busy=0, done=0, error=0; counters=0; pending flag clear.
- LED byte = {5'b0, caps, num, scroll}.
- led_state is snapshotted when req is accepted; later changes do not affect the byte in flight.
- States and transitions:
  - IDLE: if req or pending, go to SEND_ED, set busy, clear retry count and pending.
  - SEND_ED: the_command=0xED, send_command=1, then go to WAIT_TX.
  - WAIT_TX: hold send_command=1 until command_was_sent or error_communication_timed_out, then deassert send_command the next cycle.
    - command_was_sent: go to WAIT_ACK and clear the timeout counter.
    - error_communication_timed_out: treat as a retry event.
  - WAIT_ACK: the timeout counter increments every cycle.
    - received_data_en with 0xFA: advance. After 0xED go to SEND_LED. After the LED byte go to DONE.
    - received_data_en with 0xFE: retry event.
    - Any other byte (for example scan codes): ignored, and the counter is not cleared.
    - Counter reaching ACK_TIMEOUT-1: retry event.
  - SEND_LED: the_command=LED byte, send_command=1, then go to WAIT_TX. Entering SEND_LED clears the retry count.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
  - ERR: error=1 for one cycle, busy=0, go to IDLE.
- Retry event: if retry count < MAX_RETRY, increment it and re-send the current byte (0xED or LED byte). Otherwise go to ERR.
- send_command is always low for at least one cycle between two bytes.
- Minimum latency: req to send_command high is 2 cycles.
- req while busy: sets a one-deep pending flag. Extra reqs are merged into it. After DONE or ERR, the block restarts from IDLE using the led_state at that moment.
- req and DONE in the same cycle: the req becomes pending.
- Reset asserted mid-sequence: send_command drops immediately (asynchronous), all state is cleared and pending is lost.

Optional Feature:
- Macro: LED_AUTO_UPDATE_EN.
- Defined: a registered copy of led_state is compared every cycle. Any change acts as an internal req, ORed with the req port, and goes pending if busy. After reset, one update is issued automatically with the current led_state.
- Undefined: updates occur only on the req port; no comparison register is built.

Test Plan:
- Normal update: led_state=3'b101, req pulse; model returns 0xFA after each byte -> the_command 0xED then 0x05, exactly one done pulse, error never high.
- Resend: model answers the first 0xED with 0xFE -> 0xED re-sent once, then 0x05, done pulses.
- Timeout: ACK_TIMEOUT=100, MAX_RETRY=2, model never ACKs -> 0xED sent 3 times at least 100 cycles apart, error pulses once, busy=0, no done.
- Noise and pending: a 0x1C byte arrives during WAIT_ACK and is ignored; req with led_state=3'b010 while busy -> after done, a second sequence sends 0xED, 0x02.
- Controller error: error_communication_timed_out on the LED byte -> that byte is re-sent and the sequence completes.
- Reset mid-WAIT_TX: nReset low -> send_command=0 the same cycle, all outputs at reset values, no done/error.
- With LED_AUTO_UPDATE_EN: changing led_state 000->001 with no req -> sequence 0xED, 0x01.

Source files
------------

// File: rtl/ps2_led_cmd_tx_if.sv
// ps2_led_cmd_tx_if: request/status and PS/2 transmit-side signals
// slave = LED command sender, master = sequencer plus PS2_Controller side
interface ps2_led_cmd_tx_if;
    logic [2:0] led_state;
    logic       req;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] the_command;
    logic       send_command;
    logic       busy;
    logic       done;
    logic       error;

    modport slave (
        input  led_state,
        input  req,
        input  received_data,
        input  received_data_en,
        input  command_was_sent,
        input  error_communication_timed_out,
        output the_command,
        output send_command,
        output busy,
        output done,
        output error
    );

    modport master (
        output led_state,
        output req,
        output received_data,
        output received_data_en,
        output command_was_sent,
        output error_communication_timed_out,
        input  the_command,
        input  send_command,
        input  busy,
        input  done,
        input  error
    );
endinterface

// File: rtl/ps2_led_cmd_tx.sv
// ps2_led_cmd_tx: sends keyboard "Set LEDs" (0xED + LED byte) with ACK/resend/timeout.
// Optional LED_AUTO_UPDATE_EN: a change of led_state acts as an internal req.
module ps2_led_cmd_tx #(
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 22
) (
    input logic             Clock,
    input logic             nReset,
    ps2_led_cmd_tx_if.slave bus
);

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] KBD_ACK     = 8'hFA;
    localparam logic [7:0] KBD_RESEND  = 8'hFE;
    localparam int         RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_ED,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_SEND_LED,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic             send_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RW-1:0]    retry_q;
    logic             pend_q;
    logic [2:0]       led_q;
    logic             sel_led_q;

    logic             auto_chg;
    logic             req_any;
    logic             rx_ack;
    logic             rx_rsnd;
    logic             timeout;
    logic             can_retry;
    state_t           retry_state_d;
    logic [7:0]       led_byte_d;

`ifdef LED_AUTO_UPDATE_EN
    logic [2:0] led_prev_q;
    logic       prime_q;

    // Track led_state; the prime flag forces one update right after reset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            led_prev_q <= 3'b000;
            prime_q    <= 1'b1;
        end else begin
            led_prev_q <= bus.led_state;
            prime_q    <= 1'b0;
        end
    end

    assign auto_chg = prime_q | (bus.led_state != led_prev_q);
`else
    assign auto_chg = 1'b0;
`endif

    // Decode keyboard replies, timeout and the retry decision
    always_comb begin
        req_any       = bus.req | auto_chg;
        rx_ack        = bus.received_data_en && (bus.received_data == KBD_ACK);
        rx_rsnd       = bus.received_data_en && (bus.received_data == KBD_RESEND);
        timeout       = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        can_retry     = (retry_q < RW'(MAX_RETRY));
        retry_state_d = S_ERR;
        if (can_retry) begin
            retry_state_d = sel_led_q ? S_SEND_LED : S_SEND_ED;
        end
        led_byte_d    = {5'b00000, led_q};
    end

    // Command sequencer with registered outputs
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'h00;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            retry_q   <= '0;
            pend_q    <= 1'b0;
            led_q     <= 3'b000;
            sel_led_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state_q != S_IDLE) && req_any) begin
                pend_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (req_any || pend_q) begin
                        state_q   <= S_SEND_ED;
                        busy_q    <= 1'b1;
                        retry_q   <= '0;
                        pend_q    <= 1'b0;
                        led_q     <= bus.led_state;
                        sel_led_q <= 1'b0;
                    end
                end
                S_SEND_ED: begin
                    cmd_q     <= CMD_SET_LED;
                    send_q    <= 1'b1;
                    sel_led_q <= 1'b0;
                    state_q   <= S_WAIT_TX;
                end
                S_SEND_LED: begin
                    cmd_q     <= led_byte_d;
                    send_q    <= 1'b1;
                    sel_led_q <= 1'b1;
                    state_q   <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.command_was_sent) begin
                        send_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT_ACK;
                    end else if (bus.error_communication_timed_out) begin
                        send_q  <= 1'b0;
                        state_q <= retry_state_d;
                        if (can_retry) begin
                            retry_q <= retry_q + RW'(1);
                        end else begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (rx_ack) begin
                        if (sel_led_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_SEND_LED;
                            retry_q <= '0;
                        end
                    end else if (rx_rsnd || timeout) begin
                        state_q <= retry_state_d;
                        if (can_retry) begin
                            retry_q <= retry_q + RW'(1);
                        end else begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.the_command  = cmd_q;
    assign bus.send_command = send_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = err_q;

endmodule

// File: tb/tb_ps2_led_cmd_tx.sv
// tb_ps2_led_cmd_tx: scoreboard bench with a scripted PS/2 controller/keyboard model.
// Events (sent bytes, done, error) are queued as expected and checked by a monitor.
module tb_ps2_led_cmd_tx;

    localparam int EV_DONE = 256;
    localparam int EV_ERR  = 257;
    localparam int R_ACK   = 0;
    localparam int R_FE    = 1;
    localparam int R_NONE  = 2;
    localparam int R_TXERR = 3;
    localparam int R_NOISE = 4;

    logic clk;
    logic nReset;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   exp_q[$];
    int   resp_q[$];
    int   tx_cyc[$];

    ps2_led_cmd_tx_if sif ();

    ps2_led_cmd_tx #(
        .ACK_TIMEOUT(100),
        .MAX_RETRY  (2),
        .CNT_W      (8)
    ) dut (
        .Clock (clk),
        .nReset(nReset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void report_evt(input int ev);
        int e;
        e = -1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("event", ev, e);
    endfunction

    // Monitor: sent bytes (send_command rising), done and error pulses
    initial begin
        logic prev_send;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (nReset === 1'b1) begin
                if (sif.send_command && !prev_send) begin
                    tx_cyc.push_back(cyc);
                    report_evt(int'(sif.the_command));
                end
                if (sif.done) report_evt(EV_DONE);
                if (sif.error) report_evt(EV_ERR);
            end
            prev_send = sif.send_command;
        end
    end

    task automatic kbd_byte(input logic [7:0] b);
        sif.received_data    = b;
        sif.received_data_en = 1'b1;
        @(posedge clk);
        #1;
        sif.received_data_en = 1'b0;
    endtask

    // Controller + keyboard model, one scripted reply per transmitted byte
    initial begin
        int r;
        sif.command_was_sent              = 1'b0;
        sif.error_communication_timed_out = 1'b0;
        sif.received_data_en              = 1'b0;
        sif.received_data                 = 8'h00;
        forever begin
            do @(negedge clk); while (sif.send_command !== 1'b1);
            r = (resp_q.size() != 0) ? resp_q.pop_front() : R_ACK;
            repeat (3) @(posedge clk);
            #1;
            if (r == R_TXERR) sif.error_communication_timed_out = 1'b1;
            else sif.command_was_sent = 1'b1;
            @(posedge clk);
            #1;
            sif.command_was_sent              = 1'b0;
            sif.error_communication_timed_out = 1'b0;
            if (r == R_NOISE) begin
                repeat (2) @(posedge clk);
                #1;
                kbd_byte(8'h1C);
            end
            if (r == R_ACK || r == R_NOISE || r == R_FE) begin
                repeat (4) @(posedge clk);
                #1;
                kbd_byte((r == R_FE) ? 8'hFE : 8'hFA);
            end
        end
    end

    task automatic pulse_req();
        @(posedge clk);
        #1;
        sif.req = 1'b1;
        @(posedge clk);
        #1;
        sif.req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sif.busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(name, int'(n < budget), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        nReset        = 1'b0;
        sif.req       = 1'b0;
        sif.led_state = 3'b000;
`ifdef LED_AUTO_UPDATE_EN
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h00);
        exp_q.push_back(EV_DONE);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", int'(sif.the_command), 0);
        chk("rst_send", int'(sif.send_command), 0);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_done", int'(sif.done), 0);
        chk("rst_err", int'(sif.error), 0);
        nReset = 1'b1;
`ifdef LED_AUTO_UPDATE_EN
        wait_idle(2000, "auto_reset");
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h01);
        exp_q.push_back(EV_DONE);
        @(posedge clk);
        #1;
        sif.led_state = 3'b001;
        wait_idle(2000, "auto_change");
`else
        repeat (2) @(posedge clk);

        // Normal update with latency check
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h05);
        exp_q.push_back(EV_DONE);
        @(posedge clk);
        #1;
        sif.led_state = 3'b101;
        sif.req       = 1'b1;
        @(posedge clk);
        #1;
        sif.req = 1'b0;
        @(negedge clk);
        chk("lat_send_lo", int'(sif.send_command), 0);
        chk("lat_busy", int'(sif.busy), 1);
        @(negedge clk);
        chk("lat_send_hi", int'(sif.send_command), 1);
        chk("lat_cmd", int'(sif.the_command), 8'hED);
        wait_idle(2000, "normal");

        // Resend on 0xFE
        resp_q.push_back(R_FE);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h05);
        exp_q.push_back(EV_DONE);
        pulse_req();
        wait_idle(2000, "resend");

        // ACK timeout with retries exhausted
        tx_cyc.delete();
        resp_q.push_back(R_NONE);
        resp_q.push_back(R_NONE);
        resp_q.push_back(R_NONE);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'hED);
        exp_q.push_back(EV_ERR);
        pulse_req();
        wait_idle(2000, "timeout");
        chk("to_sends", tx_cyc.size(), 3);
        if (tx_cyc.size() == 3) begin
            chk("to_gap1", int'((tx_cyc[1] - tx_cyc[0]) >= 100), 1);
            chk("to_gap2", int'((tx_cyc[2] - tx_cyc[1]) >= 100), 1);
        end
        chk("to_busy", int'(sif.busy), 0);

        // Noise byte ignored, req while busy becomes pending
        resp_q.push_back(R_NOISE);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h05);
        exp_q.push_back(EV_DONE);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h02);
        exp_q.push_back(EV_DONE);
        pulse_req();
        repeat (6) @(posedge clk);
        #1;
        sif.led_state = 3'b010;
        pulse_req();
        repeat (3) @(posedge clk);
        pulse_req();
        wait_idle(2000, "pending");

        // Controller transmit error on the LED byte
        resp_q.push_back(R_ACK);
        resp_q.push_back(R_TXERR);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        exp_q.push_back(EV_DONE);
        pulse_req();
        wait_idle(2000, "txerr");

        // Reset while waiting for the controller
        exp_q.push_back(8'hED);
        @(posedge clk);
        #1;
        sif.led_state = 3'b011;
        pulse_req();
        do @(negedge clk); while (sif.send_command !== 1'b1);
        #3;
        nReset = 1'b0;
        #1;
        chk("mid_send", int'(sif.send_command), 0);
        chk("mid_cmd", int'(sif.the_command), 0);
        chk("mid_busy", int'(sif.busy), 0);
        chk("mid_done", int'(sif.done), 0);
        chk("mid_err", int'(sif.error), 0);
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_idle", int'(sif.busy), 0);
`endif
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
